// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the IF stage: fetch FSM encoding, address-map constants
// and the fetch-address legality check.
package fetch_stage_pkg;

  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [DATA_W-1:0] IM_BASE_DEF  = 32'h0000_3000;
  localparam logic [DATA_W-1:0] IM_LIMIT_DEF = 32'h0000_6FFC;

  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_WAIT = 2'd1,
    FS_HOLD = 2'd2
  } fs_state_t;

  typedef struct packed {
    logic              adel;
    logic [DATA_W-1:0] instr;
  } fetch_word_t;

  function automatic logic fetch_addr_bad(input logic [DATA_W-1:0] pc,
                                          input logic [DATA_W-1:0] base,
                                          input logic [DATA_W-1:0] limit);
    return (pc[1:0] != 2'b00) || (pc < base) || (pc > limit);
  endfunction

endpackage

// File: rtl/fetch_stage_fd_reg.sv
// F/D pipeline register: flush-to-bubble beats load, otherwise load on en or hold.
// Kept generic so the D/E register can reuse it.
module fd_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              flush,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] instr_in,
  input  logic              adel_in,
  output logic [DATA_W-1:0] pc_q,
  output logic [DATA_W-1:0] instr_q,
  output logic              valid_q,
  output logic              adel_q
);

  // A bubble keeps the PC of the slot it replaces so exception PCs stay meaningful
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      adel_q  <= 1'b0;
    end else if (flush) begin
      pc_q    <= pc_in;
      instr_q <= '0;
      valid_q <= 1'b0;
      adel_q  <= 1'b0;
    end else if (en) begin
      pc_q    <= pc_in;
      instr_q <= instr_in;
      valid_q <= 1'b1;
      adel_q  <= adel_in;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: holds PC_F, runs one outstanding fetch against a variable-latency
// instruction memory and feeds the F/D register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [DATA_W-1:0] IM_BASE  = IM_BASE_DEF,
  parameter logic [DATA_W-1:0] IM_LIMIT = IM_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] PC_next,
  input  logic              stall_D,
  input  logic              flush_D,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] PC_F,
  output logic [DATA_W-1:0] PC_D,
  output logic [DATA_W-1:0] instr_D,
  output logic              valid_D,
  output logic              exc_adel_D,
  output logic              fetch_wait
);

  fs_state_t   state, state_n;
  fetch_word_t hold_word;
  fetch_word_t done_word;
  logic        pc_bad;
  logic        fetch_done;
  logic        advance;
  logic        hold_load;

  assign pc_bad    = fetch_addr_bad(PC_F, IM_BASE, IM_LIMIT);
  assign imem_addr = PC_F;

  // A bad address completes immediately as an AdEL bubble; any rvalid seen in
  // REQ belongs to a fetch abandoned by reset and is deliberately ignored.
  always_comb begin
    state_n    = state;
    imem_req   = 1'b0;
    fetch_wait = 1'b0;
    fetch_done = 1'b0;
    done_word  = '0;
    advance    = 1'b0;
    hold_load  = 1'b0;
    case (state)
      FS_REQ: begin
        if (pc_bad) begin
          fetch_done     = 1'b1;
          done_word.adel = 1'b1;
        end else begin
          imem_req   = !reset;
          fetch_wait = 1'b1;
          state_n    = FS_WAIT;
        end
      end
      FS_WAIT: begin
        if (imem_rvalid) begin
          fetch_done      = 1'b1;
          done_word.instr = imem_rdata;
        end else begin
          fetch_wait = 1'b1;
        end
      end
      FS_HOLD: begin
        if (!stall_D) begin
          advance   = 1'b1;
          done_word = hold_word;
          state_n   = FS_REQ;
        end
      end
      default: state_n = FS_REQ;
    endcase

    if (fetch_done) begin
      if (stall_D) begin
        hold_load = 1'b1;
        state_n   = FS_HOLD;
      end else begin
        advance = 1'b1;
        state_n = FS_REQ;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FS_REQ;
    end else begin
      state <= state_n;
    end
  end

  // PC_F moves only when the fetched word leaves for D; flush does not stop it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PC_F <= RESET_PC;
    end else if (advance) begin
      PC_F <= PC_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_word <= '0;
    end else if (hold_load) begin
      hold_word <= done_word;
    end
  end

  fd_reg #(
    .RESET_PC (RESET_PC)
  ) u_fd_reg (
    .clk      (clk),
    .reset    (reset),
    .en       (advance),
    .flush    (flush_D),
    .pc_in    (PC_F),
    .instr_in (done_word.instr),
    .adel_in  (done_word.adel),
    .pc_q     (PC_D),
    .instr_q  (instr_D),
    .valid_q  (valid_D),
    .adel_q   (exc_adel_D)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: reset corner, a cycle-by-cycle vector table, then
// randomized traffic against a queue-based model of fetch delivery.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic [31:0] PC_next;
  logic        stall_D;
  logic        flush_D;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] PC_F;
  logic [31:0] PC_D;
  logic [31:0] instr_D;
  logic        valid_D;
  logic        exc_adel_D;
  logic        fetch_wait;

  int checks;
  int failures;

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .PC_next     (PC_next),
    .stall_D     (stall_D),
    .flush_D     (flush_D),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .PC_F        (PC_F),
    .PC_D        (PC_D),
    .instr_D     (instr_D),
    .valid_D     (valid_D),
    .exc_adel_D  (exc_adel_D),
    .fetch_wait  (fetch_wait)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        flush;
    logic [31:0] nxt;
    logic        rv;
    logic [31:0] rd;
    logic        req;
    logic        wt;
    logic [31:0] pcf;
    logic [31:0] pcd;
    logic [31:0] ins;
    logic        v;
    logic        adel;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic s, input logic f, input logic [31:0] nx,
                     input logic rv, input logic [31:0] rd,
                     input logic rq, input logic wt,
                     input logic [31:0] pcf, input logic [31:0] pcd,
                     input logic [31:0] ins, input logic v, input logic ad);
    vec_t r;
    r.stall = s;  r.flush = f; r.nxt = nx; r.rv = rv; r.rd = rd;
    r.req = rq;   r.wt = wt;   r.pcf = pcf; r.pcd = pcd; r.ins = ins;
    r.v = v;      r.adel = ad;
    tbl.push_back(r);
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    PC_next     = 32'h0;
    stall_D     = 1'b0;
    flush_D     = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    #3;
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  function automatic logic m_good(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= 32'h0000_3000) && (a <= 32'h0000_6FFC);
  endfunction

  // Reference model state
  logic [31:0] m_pcf, m_pcd, m_ins;
  logic        m_v, m_adel, m_inflight;
  logic [32:0] m_ready[$];

  // Memory environment state
  logic        mem_pending;
  int          mem_cnt;

  initial begin
    logic        rv, st, fl, e_req, e_wait, avail;
    logic [31:0] rd, nx;
    logic [32:0] w;

    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    PC_next  = 32'h0;
    stall_D  = 1'b0;
    flush_D  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;

    // ---- reset behaviour, including reset mid-WAIT with a stale rvalid ----
    #12;
    chk1 ("rst_req_low", imem_req, 1'b0);
    chk32("rst_pcf", PC_F, 32'h3000);
    chk32("rst_pcd", PC_D, 32'h3000);
    chk32("rst_instr", instr_D, 32'h0);
    chk1 ("rst_valid", valid_D, 1'b0);
    chk1 ("rst_adel", exc_adel_D, 1'b0);
    reset = 1'b0;
    #1;
    chk1 ("first_req", imem_req, 1'b1);
    chk32("first_addr", imem_addr, 32'h3000);
    chk1 ("first_wait", fetch_wait, 1'b1);
    @(posedge clk);
    #2;
    reset       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    #1;
    chk1 ("midwait_rst_req", imem_req, 1'b0);
    chk32("midwait_rst_pcf", PC_F, 32'h3000);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk1 ("post_rst_req", imem_req, 1'b1);
    chk32("post_rst_addr", imem_addr, 32'h3000);
    @(posedge clk);
    #1;
    chk1 ("stale_rv_ignored_valid", valid_D, 1'b0);
    chk32("stale_rv_ignored_pcf", PC_F, 32'h3000);
    imem_rvalid = 1'b0;
    #1;
    chk1 ("post_rst_wait", fetch_wait, 1'b1);
    chk1 ("post_rst_noreq", imem_req, 1'b0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h3C01_0001;
    PC_next     = 32'h3004;
    @(posedge clk);
    #1;
    chk1 ("post_rst_deliver_valid", valid_D, 1'b1);
    chk32("post_rst_deliver_instr", instr_D, 32'h3C01_0001);
    chk32("post_rst_deliver_pcd", PC_D, 32'h3000);
    chk32("post_rst_deliver_pcf", PC_F, 32'h3004);

    // ---- vector table: s f next rv rdata | req wait | pcf pcd instr v adel ----
    row(1'b0,1'b0,32'h3004,1'b0,32'h0,         1'b1,1'b1, 32'h3000,32'h3000,32'h0,        1'b0,1'b0);
    row(1'b0,1'b0,32'h3004,1'b1,32'h3C010001,  1'b0,1'b0, 32'h3004,32'h3000,32'h3C010001, 1'b1,1'b0);
    row(1'b0,1'b0,32'h3008,1'b0,32'h0,         1'b1,1'b1, 32'h3004,32'h3000,32'h3C010001, 1'b1,1'b0);
    row(1'b0,1'b0,32'h3008,1'b1,32'h3C010005,  1'b0,1'b0, 32'h3008,32'h3004,32'h3C010005, 1'b1,1'b0);
    row(1'b0,1'b0,32'h300C,1'b0,32'h0,         1'b1,1'b1, 32'h3008,32'h3004,32'h3C010005, 1'b1,1'b0);
    row(1'b0,1'b0,32'h300C,1'b0,32'h0,         1'b0,1'b1, 32'h3008,32'h3004,32'h3C010005, 1'b1,1'b0);
    row(1'b0,1'b0,32'h300C,1'b0,32'h0,         1'b0,1'b1, 32'h3008,32'h3004,32'h3C010005, 1'b1,1'b0);
    row(1'b0,1'b0,32'h300C,1'b1,32'h3C010009,  1'b0,1'b0, 32'h300C,32'h3008,32'h3C010009, 1'b1,1'b0);
    row(1'b0,1'b0,32'h3010,1'b0,32'h0,         1'b1,1'b1, 32'h300C,32'h3008,32'h3C010009, 1'b1,1'b0);
    row(1'b1,1'b0,32'h3010,1'b1,32'h3C01000D,  1'b0,1'b0, 32'h300C,32'h3008,32'h3C010009, 1'b1,1'b0);
    row(1'b1,1'b0,32'h3010,1'b0,32'h0,         1'b0,1'b0, 32'h300C,32'h3008,32'h3C010009, 1'b1,1'b0);
    row(1'b0,1'b0,32'h3002,1'b0,32'h0,         1'b0,1'b0, 32'h3002,32'h300C,32'h3C01000D, 1'b1,1'b0);
    row(1'b0,1'b0,32'h7000,1'b0,32'h0,         1'b0,1'b0, 32'h7000,32'h3002,32'h0,        1'b1,1'b1);
    row(1'b0,1'b0,32'h3010,1'b0,32'h0,         1'b0,1'b0, 32'h3010,32'h7000,32'h0,        1'b1,1'b1);
    row(1'b0,1'b0,32'h3014,1'b0,32'h0,         1'b1,1'b1, 32'h3010,32'h7000,32'h0,        1'b1,1'b1);
    row(1'b1,1'b1,32'h3014,1'b0,32'h0,         1'b0,1'b1, 32'h3010,32'h3010,32'h0,        1'b0,1'b0);
    row(1'b1,1'b0,32'h3014,1'b1,32'h3C010011,  1'b0,1'b0, 32'h3010,32'h3010,32'h0,        1'b0,1'b0);
    row(1'b0,1'b0,32'h3014,1'b0,32'h0,         1'b0,1'b0, 32'h3014,32'h3010,32'h3C010011, 1'b1,1'b0);
    row(1'b0,1'b0,32'h3018,1'b0,32'h0,         1'b1,1'b1, 32'h3014,32'h3010,32'h3C010011, 1'b1,1'b0);
    row(1'b0,1'b1,32'h3018,1'b1,32'h3C010015,  1'b0,1'b0, 32'h3018,32'h3014,32'h0,        1'b0,1'b0);
    row(1'b0,1'b0,32'h301C,1'b0,32'h0,         1'b1,1'b1, 32'h3018,32'h3014,32'h0,        1'b0,1'b0);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      stall_D     = tbl[i].stall;
      flush_D     = tbl[i].flush;
      PC_next     = tbl[i].nxt;
      imem_rvalid = tbl[i].rv;
      imem_rdata  = tbl[i].rd;
      #1;
      chk1($sformatf("vec%0d_req", i), imem_req, tbl[i].req);
      chk1($sformatf("vec%0d_wait", i), fetch_wait, tbl[i].wt);
      @(posedge clk);
      #1;
      chk32($sformatf("vec%0d_pcf", i), PC_F, tbl[i].pcf);
      chk32($sformatf("vec%0d_pcd", i), PC_D, tbl[i].pcd);
      chk32($sformatf("vec%0d_instr", i), instr_D, tbl[i].ins);
      chk1 ($sformatf("vec%0d_valid", i), valid_D, tbl[i].v);
      chk1 ($sformatf("vec%0d_adel", i), exc_adel_D, tbl[i].adel);
      #1;
    end

    // ---- randomized traffic against the delivery model ----
    do_reset();
    m_pcf = 32'h3000; m_pcd = 32'h3000; m_ins = 32'h0;
    m_v = 1'b0; m_adel = 1'b0; m_inflight = 1'b0;
    m_ready.delete();
    mem_pending = 1'b0;
    mem_cnt = 0;

    for (int c = 0; c < 3000; c++) begin
      if (mem_pending) rv = (mem_cnt == 1);
      else             rv = ($urandom_range(0, 7) == 0);
      rd = $urandom;
      st = ($urandom_range(0, 9) < 3);
      fl = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 11))
        0:       nx = m_pcf + 32'd2;
        1:       nx = 32'h7000;
        2:       nx = 32'h2FFC;
        3:       nx = 32'h6FFC;
        4, 5:    nx = 32'h3000 + ($urandom_range(0, 4095) << 2);
        default: nx = m_pcf + 32'd4;
      endcase
      stall_D     = st;
      flush_D     = fl;
      PC_next     = nx;
      imem_rvalid = rv;
      imem_rdata  = rd;
      #1;

      e_req  = !m_inflight && (m_ready.size() == 0) && m_good(m_pcf);
      e_wait = (m_inflight && !rv) || e_req;
      chk1 ("rnd_req", imem_req, e_req);
      chk1 ("rnd_wait", fetch_wait, e_wait);
      chk32("rnd_addr", imem_addr, m_pcf);
      chk32("rnd_pcf", PC_F, m_pcf);
      chk32("rnd_pcd", PC_D, m_pcd);
      chk32("rnd_instr", instr_D, m_ins);
      chk1 ("rnd_valid", valid_D, m_v);
      chk1 ("rnd_adel", exc_adel_D, m_adel);

      // memory responds 1..3 cycles after each request it sees
      if (mem_pending) begin
        if (rv) mem_pending = 1'b0;
        else    mem_cnt--;
      end
      if (imem_req) begin
        mem_pending = 1'b1;
        mem_cnt     = $urandom_range(1, 3);
      end

      // a word is available if parked, just returned, or a bad PC needs no memory
      avail = 1'b0;
      w     = '0;
      if (m_ready.size() > 0) begin
        avail = 1'b1;
        w     = m_ready[0];
      end else if (m_inflight && rv) begin
        avail = 1'b1;
        w     = {1'b0, rd};
      end else if (!m_inflight && !m_good(m_pcf)) begin
        avail = 1'b1;
        w     = {1'b1, 32'h0};
      end
      if (avail && !st) begin
        m_pcd  = m_pcf;
        m_ins  = w[31:0];
        m_v    = 1'b1;
        m_adel = w[32];
        m_pcf  = nx;
        m_ready.delete();
        m_inflight = 1'b0;
      end else if (avail) begin
        if (m_ready.size() == 0) m_ready.push_back(w);
        m_inflight = 1'b0;
      end
      if (e_req) m_inflight = 1'b1;
      if (fl) begin
        m_pcd  = (avail && !st) ? m_pcd : m_pcf;
        m_ins  = 32'h0;
        m_v    = 1'b0;
        m_adel = 1'b0;
      end

      @(posedge clk);
      #2;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
